cd_sector_sync: RTL and testbench

- Upstream stage of the CD decoder register block.
- Takes the raw 2352-byte CD-ROM sector byte stream from the drive interface and locates the 12-byte sync pattern.
- Extracts the 4-byte header and writes header plus data into the sector buffer.
- Produces the header, status and pointer values that the register block returns on reads, plus a one-cycle decode-done pulse.

---
 rtl/cd_sector_sync.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cd_sector_sync.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_sector_sync.sv
// cd_sector_sync: finds CD-ROM sector sync, extracts the header and buffers header+data.
// Optional build macro: CD_DESCRAMBLE_EN (ECMA-130 descrambling of sector bytes 12..2351).
//
// Ports:
//   CLK_12M     system clock, all logic on the rising edge
//   RESET       synchronous active-high reset
//   DECEN       decoder enable; low forces HUNT and blocks buffer writes
//   BYTE_VALID  BYTE_IN carries a sector byte this cycle
//   BYTE_IN     raw sector byte
//   WA_LOAD     load write address from WA_IN (wins over increment)
//   WA_IN       new write address
//   BUF_WE      buffer write strobe, one cycle after the byte
//   BUF_ADDR    buffer write address (current WA)
//   BUF_DATA    buffer write data
//   HEAD        {minute, second, frame, mode} of the last completed sector
//   PT          buffer address of header byte 0 of the last completed sector
//   WA          current write address
//   LOCKED      sync lock held
//   MISSES      consecutive missed syncs while locked
//   DECI        one-cycle sector-complete pulse
module cd_sector_sync #(
   parameter int BUF_AW   = 14,
   parameter int MISS_MAX = 3
) (
   input  logic              CLK_12M,
   input  logic              RESET,
   input  logic              DECEN,
   input  logic              BYTE_VALID,
   input  logic [7:0]        BYTE_IN,
   input  logic              WA_LOAD,
   input  logic [BUF_AW-1:0] WA_IN,
   output logic              BUF_WE,
   output logic [BUF_AW-1:0] BUF_ADDR,
   output logic [7:0]        BUF_DATA,
   output logic [31:0]       HEAD,
   output logic [BUF_AW-1:0] PT,
   output logic [BUF_AW-1:0] WA,
   output logic              LOCKED,
   output logic [1:0]        MISSES,
   output logic              DECI
);

   typedef enum logic [1:0] {
      S_HUNT,
      S_HEADER,
      S_DATA,
      S_SYNC
   } state_t;

   localparam logic [95:0] SYNC_PAT = {8'h00, {10{8'hFF}}, 8'h00};
   localparam logic [11:0] HDR_LAST  = 12'd3;
   localparam logic [11:0] DATA_LAST = 12'd2335;
   localparam logic [11:0] SYNC_LAST = 12'd11;
   localparam logic [BUF_AW-1:0] WA_ONE = 1;

   state_t r_state;
   state_t w_state_nxt;
   logic [11:0] r_cnt;
   logic [11:0] w_cnt_nxt;
   logic r_locked;
   logic w_lock_nxt;
   logic [1:0] r_miss;
   logic [1:0] w_miss_nxt;

   logic [95:0] r_sh;
   logic [95:0] w_shift;
   logic w_match;

   logic w_wr;
   logic w_hdr;
   logic w_hdr0;
   logic w_last;
   logic w_sync_end;
   logic [7:0] w_db;

   logic r_we;
   logic r_hdr0;
   logic r_last;
   logic [7:0] r_data;
   logic [31:0] r_hsh;
   logic [BUF_AW-1:0] r_wa;
   logic [BUF_AW-1:0] r_pt_sh;
   logic [BUF_AW-1:0] r_pt;
   logic [31:0] r_head;
   logic r_deci;

   // Detection always looks at raw bytes, including the incoming one.
   assign w_shift = {r_sh[87:0], BYTE_IN};
   assign w_match = (w_shift == SYNC_PAT);

`ifdef CD_DESCRAMBLE_EN
   logic [14:0] r_lfsr;
   logic [14:0] w_lfsr_nxt;
   logic [7:0]  w_key;

   // Eight LFSR steps per byte, key bits emitted LSB first.
   always_comb begin
      w_lfsr_nxt = r_lfsr;
      w_key      = '0;
      for (int b = 0; b < 8; b++) begin
         w_key[b]   = w_lfsr_nxt[0];
         w_lfsr_nxt = {w_lfsr_nxt[0] ^ w_lfsr_nxt[1], w_lfsr_nxt[14:1]};
      end
   end

   always_ff @(posedge CLK_12M) begin
      if (RESET) begin
         r_lfsr <= 15'h0001;
      end else if (w_sync_end) begin
         r_lfsr <= 15'h0001;
      end else if (w_wr) begin
         r_lfsr <= w_lfsr_nxt;
      end
   end

   assign w_db = BYTE_IN ^ w_key;
`else
   assign w_db = BYTE_IN;
`endif

   always_ff @(posedge CLK_12M) begin
      if (RESET) begin
         r_state  <= S_HUNT;
         r_cnt    <= '0;
         r_locked <= 1'b0;
         r_miss   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_locked <= w_lock_nxt;
         r_miss   <= w_miss_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lock_nxt  = r_locked;
      w_miss_nxt  = r_miss;
      w_wr        = 1'b0;
      w_hdr       = 1'b0;
      w_hdr0      = 1'b0;
      w_last      = 1'b0;
      w_sync_end  = 1'b0;
      if (!DECEN) begin
         w_state_nxt = S_HUNT;
         w_cnt_nxt   = '0;
         w_lock_nxt  = 1'b0;
         w_miss_nxt  = '0;
      end else if (BYTE_VALID) begin
         unique case (r_state)
            S_HUNT: begin
               if (w_match) begin
                  w_state_nxt = S_HEADER;
                  w_cnt_nxt   = '0;
                  w_lock_nxt  = 1'b1;
                  w_miss_nxt  = '0;
                  w_sync_end  = 1'b1;
               end
            end
            S_HEADER: begin
               w_wr   = 1'b1;
               w_hdr  = 1'b1;
               w_hdr0 = (r_cnt == '0);
               if (r_cnt == HDR_LAST) begin
                  w_state_nxt = S_DATA;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 12'd1;
               end
            end
            S_DATA: begin
               w_wr = 1'b1;
               if (r_cnt == DATA_LAST) begin
                  w_state_nxt = S_SYNC;
                  w_cnt_nxt   = '0;
                  w_last      = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 12'd1;
               end
            end
            S_SYNC: begin
               if (r_cnt == SYNC_LAST) begin
                  // The shift register now holds exactly this sync field.
                  w_cnt_nxt = '0;
                  if (w_match) begin
                     w_state_nxt = S_HEADER;
                     w_miss_nxt  = '0;
                     w_sync_end  = 1'b1;
                  end else if (int'(r_miss) + 1 < MISS_MAX) begin
                     w_state_nxt = S_HEADER;
                     w_miss_nxt  = r_miss + 2'd1;
                     w_sync_end  = 1'b1;
                  end else begin
                     w_state_nxt = S_HUNT;
                     w_lock_nxt  = 1'b0;
                     w_miss_nxt  = '0;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 12'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK_12M) begin
      if (RESET) begin
         r_sh    <= '0;
         r_we    <= 1'b0;
         r_hdr0  <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
         r_hsh   <= '0;
         r_wa    <= '0;
         r_pt_sh <= '0;
         r_pt    <= '0;
         r_head  <= '0;
         r_deci  <= 1'b0;
      end else begin
         if (BYTE_VALID) begin
            r_sh <= w_shift;
         end
         r_we   <= w_wr;
         r_hdr0 <= w_hdr0;
         r_last <= w_last;
         if (w_wr) begin
            r_data <= w_db;
         end
         if (w_hdr) begin
            r_hsh <= {r_hsh[23:0], w_db};
         end
         // A write in flight uses the old address; a load redirects later ones.
         if (WA_LOAD) begin
            r_wa <= WA_IN;
         end else if (r_we) begin
            r_wa <= r_wa + WA_ONE;
         end
         if (r_we && r_hdr0) begin
            r_pt_sh <= r_wa;
         end
         r_deci <= 1'b0;
         if (r_we && r_last && DECEN) begin
            r_deci <= 1'b1;
            r_head <= r_hsh;
            r_pt   <= r_pt_sh;
         end
      end
   end

   assign BUF_WE   = r_we;
   assign BUF_ADDR = r_wa;
   assign BUF_DATA = r_data;
   assign HEAD     = r_head;
   assign PT       = r_pt;
   assign WA       = r_wa;
   assign LOCKED   = r_locked;
   assign MISSES   = r_miss;
   assign DECI     = r_deci;

endmodule

// File: tb/tb_cd_sector_sync.sv
// tb_cd_sector_sync: scoreboard bench for cd_sector_sync.
// Works in both the raw and the CD_DESCRAMBLE_EN build.
module tb_cd_sector_sync;

   logic        CLK_12M = 1'b0;
   logic        RESET;
   logic        DECEN;
   logic        BYTE_VALID;
   logic [7:0]  BYTE_IN;
   logic        WA_LOAD;
   logic [13:0] WA_IN;
   logic        BUF_WE;
   logic [13:0] BUF_ADDR;
   logic [7:0]  BUF_DATA;
   logic [31:0] HEAD;
   logic [13:0] PT;
   logic [13:0] WA;
   logic        LOCKED;
   logic [1:0]  MISSES;
   logic        DECI;

   cd_sector_sync dut (
      .CLK_12M(CLK_12M), .RESET(RESET), .DECEN(DECEN),
      .BYTE_VALID(BYTE_VALID), .BYTE_IN(BYTE_IN),
      .WA_LOAD(WA_LOAD), .WA_IN(WA_IN),
      .BUF_WE(BUF_WE), .BUF_ADDR(BUF_ADDR), .BUF_DATA(BUF_DATA),
      .HEAD(HEAD), .PT(PT), .WA(WA), .LOCKED(LOCKED),
      .MISSES(MISSES), .DECI(DECI)
   );

   always #5 CLK_12M = ~CLK_12M;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int deci_cnt = 0;
   int last_deci = 0;
   int prev_deci = 0;
   logic [13:0] last_pt_seen = '0;
   logic [13:0] prev_pt_seen = '0;

   logic [21:0] exp_q[$];
   logic [13:0] m_wa = '0;
   logic [13:0] m_pt = '0;
   logic [13:0] m_pt_sh = '0;
   logic [31:0] m_head = '0;
   logic [7:0]  keytab[2340];

   // One clock: drain the scoreboard at the negedge, then move past the posedge.
   task automatic clk_step();
      logic [21:0] e;
      @(negedge CLK_12M);
      if (BUF_WE === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_write got addr=%h data=%h required no write",
                     BUF_ADDR, BUF_DATA);
         end else begin
            e = exp_q.pop_front();
            if ({BUF_ADDR, BUF_DATA} !== e) begin
               errors++;
               $display("FAIL sb_write got addr=%h data=%h required addr=%h data=%h",
                        BUF_ADDR, BUF_DATA, e[21:8], e[7:0]);
            end
         end
      end
      if (DECI === 1'b1) begin
         deci_cnt++;
         prev_deci = last_deci;
         last_deci = cyc;
         prev_pt_seen = last_pt_seen;
         last_pt_seen = PT;
      end
      @(posedge CLK_12M);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) clk_step();
   endtask

   task automatic put(input logic [7:0] b, input bit wr, input logic [7:0] plain);
      BYTE_VALID = 1'b1;
      BYTE_IN = b;
      if (wr) begin
         exp_q.push_back({m_wa, plain});
         m_wa = m_wa + 14'd1;
      end
      clk_step();
      BYTE_VALID = 1'b0;
      BYTE_IN = '0;
   endtask

   // Plaintext header hdr, data (i & FF); raw byte = plain ^ scrambler key.
   task automatic send_sector(input logic [31:0] hdr, input bit bad, input bit wr,
                              input int drop_at, input int cut_at);
      logic [7:0] s;
      logic [7:0] p;
      bit dropped;
      dropped = 0;
      for (int k = 0; k < 12; k++) begin
         s = (k == 0 || k == 11) ? 8'h00 : 8'hFF;
         if (bad && k == 5) s = 8'h7E;
         put(s, 1'b0, 8'h00);
      end
      for (int n = 0; n < 2340; n++) begin
         if (cut_at >= 0 && n == cut_at + 4) break;
         if (drop_at >= 0 && n == drop_at + 4) begin
            DECEN = 1'b0;
            dropped = 1;
         end
         if (n < 4) p = hdr[8*(3-n) +: 8];
         else p = 8'(n - 4);
         if (wr && !dropped && n == 0) m_pt_sh = m_wa;
         put(p ^ keytab[n], wr && !dropped, p);
      end
      if (wr && !dropped && cut_at < 0) begin
         m_head = hdr;
         m_pt = m_pt_sh;
      end
   endtask

   task automatic check_sector(input string nm, input int d0, input int dexp);
      checks++;
      if (deci_cnt - d0 !== dexp) begin
         errors++;
         $display("FAIL %s_deci got=%0d required=%0d", nm, deci_cnt - d0, dexp);
      end
      checks++;
      if (HEAD !== m_head) begin
         errors++;
         $display("FAIL %s_head got=%h required=%h", nm, HEAD, m_head);
      end
      checks++;
      if (PT !== m_pt) begin
         errors++;
         $display("FAIL %s_pt got=%h required=%h", nm, PT, m_pt);
      end
      checks++;
      if (WA !== m_wa) begin
         errors++;
         $display("FAIL %s_wa got=%h required=%h", nm, WA, m_wa);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_writes got=%0d required=0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      idle(3);
      checks++;
      if ({BUF_WE, LOCKED, MISSES, DECI} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b required=00000",
                  {BUF_WE, LOCKED, MISSES, DECI});
      end
      checks++;
      if ({BUF_ADDR, WA, PT} !== 42'b0) begin
         errors++;
         $display("FAIL reset_addr got=%h/%h/%h required=0", BUF_ADDR, WA, PT);
      end
      checks++;
      if ({HEAD, BUF_DATA} !== 40'b0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h required=0", HEAD, BUF_DATA);
      end
      RESET = 1'b0;
      idle(2);
   endtask

   task automatic test_single();
      int d0;
      d0 = deci_cnt;
      for (int j = 0; j < 5; j++) put(8'h11 * 8'(j + 1), 1'b0, 8'h00);
      send_sector(32'h00021601, 1'b0, 1'b1, -1, -1);
      idle(4);
      check_sector("single", d0, 1);
      checks++;
      if (HEAD !== 32'h00021601 || PT !== 14'd0 || WA !== 14'd2340) begin
         errors++;
         $display("FAIL single_abs got head=%h pt=%0d wa=%0d required 00021601/0/2340",
                  HEAD, PT, WA);
      end
      checks++;
      if (LOCKED !== 1'b1) begin
         errors++;
         $display("FAIL single_locked got=%b required=1", LOCKED);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [13:0] pt1;
      logic [13:0] pt2;
      d0 = deci_cnt;
      WA_LOAD = 1'b1;
      WA_IN = 14'h3FF0;
      clk_step();
      WA_LOAD = 1'b0;
      m_wa = 14'h3FF0;
      send_sector(32'h00021701, 1'b0, 1'b1, -1, -1);
      pt1 = m_pt;
      send_sector(32'h00021801, 1'b0, 1'b1, -1, -1);
      idle(4);
      check_sector("b2b", d0, 2);
      pt2 = 14'((32'h3FF0 + 2340) % 16384);
      checks++;
      if (PT !== pt2) begin
         errors++;
         $display("FAIL b2b_pt2 got=%h required=%h", PT, pt2);
      end
      checks++;
      if (prev_pt_seen !== 14'h3FF0 || pt1 !== 14'h3FF0) begin
         errors++;
         $display("FAIL b2b_pt1 got=%h required=3ff0", prev_pt_seen);
      end
      checks++;
      if (last_deci - prev_deci !== 2352) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d required=2352", last_deci - prev_deci);
      end
   endtask

   task automatic test_misses();
      int d0;
      logic [2:0] st;
      for (int s = 0; s < 3; s++) begin
         d0 = deci_cnt;
         send_sector(32'h00030001 + 32'(s), 1'b1, s < 2, -1, -1);
         idle(4);
         check_sector("miss", d0, (s < 2) ? 1 : 0);
         st = (s == 0) ? 3'b101 : (s == 1) ? 3'b110 : 3'b000;
         checks++;
         if ({LOCKED, MISSES} !== st) begin
            errors++;
            $display("FAIL miss%0d_state got=%b required=%b", s, {LOCKED, MISSES}, st);
         end
      end
      d0 = deci_cnt;
      send_sector(32'h00031001, 1'b0, 1'b1, -1, -1);
      idle(4);
      check_sector("relock", d0, 1);
      checks++;
      if ({LOCKED, MISSES} !== 3'b100) begin
         errors++;
         $display("FAIL relock_state got=%b required=100", {LOCKED, MISSES});
      end
   endtask

   task automatic test_decen();
      int d0;
      d0 = deci_cnt;
      send_sector(32'h00040001, 1'b0, 1'b1, 1000, -1);
      idle(4);
      check_sector("decen_off", d0, 0);
      checks++;
      if (LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL decen_locked got=%b required=0", LOCKED);
      end
      DECEN = 1'b1;
      idle(2);
      d0 = deci_cnt;
      send_sector(32'h00040101, 1'b0, 1'b1, -1, -1);
      idle(4);
      check_sector("decen_on", d0, 1);
   endtask

   task automatic test_reset_mid();
      int d0;
      d0 = deci_cnt;
      send_sector(32'h00050001, 1'b0, 1'b1, -1, 500);
      RESET = 1'b1;
      clk_step();
      checks++;
      if ({BUF_WE, LOCKED, MISSES, DECI, BUF_ADDR, WA, PT, HEAD, BUF_DATA} !== 87'b0) begin
         errors++;
         $display("FAIL rstmid_outputs got we=%b lk=%b ms=%0d wa=%h pt=%h head=%h required 0",
                  BUF_WE, LOCKED, MISSES, WA, PT, HEAD);
      end
      RESET = 1'b0;
      m_wa = '0;
      m_pt = '0;
      m_head = '0;
      exp_q.delete();
      for (int j = 0; j < 3; j++) put(8'h5A, 1'b0, 8'h00);
      send_sector(32'h00050101, 1'b0, 1'b1, -1, -1);
      idle(4);
      check_sector("rstmid", d0, 1);
   endtask

   task automatic test_zero_header();
      int d0;
      d0 = deci_cnt;
      send_sector(32'h00000000, 1'b0, 1'b1, -1, -1);
      idle(4);
      check_sector("zerohdr", d0, 1);
   endtask

   initial begin
      logic [14:0] l;
      logic [7:0]  k;
      l = 15'h0001;
      for (int n = 0; n < 2340; n++) begin
         k = '0;
`ifdef CD_DESCRAMBLE_EN
         for (int b = 0; b < 8; b++) begin
            k[b] = l[0];
            l = {l[0] ^ l[1], l[14:1]};
         end
`endif
         keytab[n] = k;
      end
      RESET = 1'b1;
      DECEN = 1'b1;
      BYTE_VALID = 1'b0;
      BYTE_IN = '0;
      WA_LOAD = 1'b0;
      WA_IN = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_misses();
      test_decen();
      test_reset_mid();
      test_zero_header();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
